hpdcache_burst_arb: RTL
=======================

// Module: hpdcache_burst_arb
// PURPOSE
//  Shares one downstream valid/ready beat channel between N requesters. Multi-beat bursts are
//  granted atomically: a burst that has started is never interleaved with another requester.
//  Fairness is round-robin at burst granularity. The output is fully registered, one beat deep,
//  with full throughput. Sits in front of shared refill/write-back ports of the cache.
// PARAMETERS
//  N          4   number of requesters (>=1)
//  DATA_W     64  beat payload width
//  MAX_BEATS  8   max beats per burst; a burst reaching this length is force-terminated
// PORTS
//  clk_i        in   1          clock
//  rst_ni       in   1          reset, asynchronous, active-low
//  req_valid_i  in   N          per-requester beat valid
//  req_ready_o  out  N          per-requester beat accept (at most one bit set)
//  req_data_i   in   N*DATA_W   per-requester payload, requester k at [k*DATA_W +: DATA_W]
//  req_last_i   in   N          per-requester last-beat-of-burst flag
//  out_valid_o  out  1          registered output valid
//  out_ready_i  in   1          downstream accept
//  out_data_o   out  DATA_W     registered payload
//  out_last_o   out  1          registered last flag (forced 1 on truncation)
//  out_id_o     out  ID_W       source requester index; ID_W = N>1 ? $clog2(N) : 1
//  err_burst_o  out  1          registered 1-cycle pulse: burst truncated at MAX_BEATS
// BEHAVIOUR
//  - Reset values: out_valid_o=0, out_data_o=0, out_last_o=0, out_id_o=0, err_burst_o=0,
//    state=IDLE, beat_cnt=0, priority pointer=requester 0. req_ready_o=0 while rst_ni=0.
//  - Handshake: a beat transfers when req_valid_i[k] & req_ready_o[k]. Requesters hold valid and
//    data stable until accepted. req_ready_o may depend combinationally on out_ready_i and req_valid_i.
//  - Output stage: can_load = !out_valid_o | out_ready_i. An accepted beat appears on out_* the
//    next cycle (latency 1). Load and drain in the same cycle give 1 beat/cycle. out_* hold while
//    out_valid_o & !out_ready_i.
//  - FSM IDLE: a round-robin pick selects grant g among asserted valids, starting the search at the
//    pointer and wrapping. req_ready_o = onehot(g) & can_load. On a transfer:
//    - last (or MAX_BEATS==1): stay IDLE, pointer <= (g+1) mod N.
//    - otherwise: owner <= g, beat_cnt <= 1, go LOCKED.
//  - FSM LOCKED: req_ready_o = onehot(owner) & req_valid_i[owner] & can_load. Others are ignored
//    even if owner drops valid (gaps allowed, lock is held).
//    - Each transfer increments beat_cnt.
//    - Transfer with last: out_last_o=1, go IDLE, beat_cnt <= 0, pointer <= (owner+1) mod N.
//    - Transfer with beat_cnt==MAX_BEATS-1 and !last: same as last, plus err_burst_o=1 next cycle.
//      Further owner beats are treated as a new burst.
//  - Grant decision for a cycle ignores the same cycle's out_ready_i except via can_load.
//    Pointer updates only on burst completion, never on stall.
//  - N==1: pointer/ID fixed at 0; bursts still counted and truncated.
//  - Async reset mid-burst or with out_valid_o=1: the pending beat is dropped and the lock is
//    released. No recovery of partial bursts.
//  - beat_cnt width: $clog2(MAX_BEATS+1); it never wraps.
// STRUCTURE
//  - Shared package hpdcache_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} hpdcache_burst_arb_st_e.
//  - Sub-module: two hpdcache_prio_1hot_encoder instances (masked by thermometer of pointer,
//    unmasked fallback) form the rotating pick. The payload mux is one-hot AND-OR on the grant.
//  - Assertions: $onehot0(req_ready_o); in LOCKED, req_ready_o & ~onehot(owner) == 0;
//    out_* stable while out_valid_o & !out_ready_i.
// TESTING
//  1 Reset: rst_ni=0 with all valids=1 -> all outputs 0, req_ready_o=0. First grant after release
//    goes to requester 0.
//  2 Fairness: N=4, all requesters issue single-beat bursts continuously, out_ready_i=1 ->
//    out_id_o sequence 0,1,2,3,0,... with one beat per cycle.
//  3 Atomicity: req0 sends a 3-beat burst, req2 valid throughout, req0 drops valid for 2 cycles
//    mid-burst -> out_id_o=0 x3 then 2. req_ready_o[2]=0 until req0's last beat transfers.
//  4 Backpressure: out_ready_i=0 for 5 cycles with out_valid_o=1 -> out_* constant, req_ready_o=0.
//    On release, 1 beat/cycle resumes with no loss or duplication.
//  5 Truncation: MAX_BEATS=8, req1 streams 10 beats, last only on 10th -> beat 8 has out_last_o=1
//    and err_burst_o pulses one cycle later. Beats 9-10 form a new burst after other pending
//    requesters are served.
//  6 Reset mid-burst: assert rst_ni=0 after beat 2 of 4 -> out_valid_o=0, state IDLE, pointer=0.
//    Next grant is by priority from requester 0.

Source files
------------

// File: rtl/hpdcache_pkg.sv
// Shared cache-side definitions: burst arbiter state encoding and sizing helpers.
package hpdcache_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } hpdcache_burst_arb_st_e;

  // Requester index width; a single requester still gets a 1-bit id field.
  function automatic int unsigned arb_id_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/hpdcache_burst_arb_chk.sv
// Protocol checker for the burst arbiter: grant exclusivity, lock integrity, output hold.
module hpdcache_burst_arb_chk #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 2
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic [N-1:0]      req_ready,
  input logic [N-1:0]      owner_1hot,
  input logic              locked,
  input logic              out_valid,
  input logic              out_ready,
  input logic [DATA_W-1:0] out_data,
  input logic              out_last,
  input logic [ID_W-1:0]   out_id
);

  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready));

  a_lock_owner_only : assert property (@(posedge clk_i) disable iff (!rst_ni)
    locked |-> ((req_ready & ~owner_1hot) == '0));

  a_out_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)
                                   && $stable(out_id)));

endmodule

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Fixed-priority pick: returns the lowest set bit of the request vector as a one-hot word.
module hpdcache_prio_1hot_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic found_s;

  // Scan upward from bit 0; the first asserted request wins.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      gnt[k]  = req[k] & ~found_s;
      found_s = found_s | req[k];
    end
  end

endmodule

// File: rtl/hpdcache_burst_arb.sv
// N-to-1 valid/ready beat arbiter with atomic multi-beat bursts, burst-level round robin
// and a one-deep registered output stage.
module hpdcache_burst_arb
  import hpdcache_pkg::*;
#(
  parameter  int unsigned N         = 4,
  parameter  int unsigned DATA_W    = 64,
  parameter  int unsigned MAX_BEATS = 8,
  localparam int unsigned ID_W      = arb_id_w(N)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N-1:0]        req_valid_i,
  output logic [N-1:0]        req_ready_o,
  input  logic [N*DATA_W-1:0] req_data_i,
  input  logic [N-1:0]        req_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic                out_last_o,
  output logic [ID_W-1:0]     out_id_o,
  output logic                err_burst_o
);

  localparam int unsigned       CNT_W       = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]  CNT_TRUNC   = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]   ID_LAST     = ID_W'(N - 1);
  localparam logic              SINGLE_BEAT = (MAX_BEATS == 1) ? 1'b1 : 1'b0;

  hpdcache_burst_arb_st_e state_r, state_n_s;
  logic [ID_W-1:0]   owner_r, owner_n_s;
  logic [ID_W-1:0]   ptr_r, ptr_n_s;
  logic [CNT_W-1:0]  beat_cnt_r, beat_cnt_n_s;

  logic [N-1:0]      thermo_s, owner_1hot_s, masked_req_s;
  logic [N-1:0]      masked_gnt_s, raw_gnt_s, pick_s, gnt_s, ready_s;
  logic              can_load_s, xfer_s, last_in_s, burst_end_s, trunc_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic [DATA_W-1:0] data_mux_s;

  logic              out_valid_r, out_last_r, err_burst_r;
  logic [DATA_W-1:0] out_data_r;
  logic [ID_W-1:0]   out_id_r;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
    return (idx == ID_LAST) ? '0 : idx + ID_W'(1);
  endfunction

  // Thermometer mask from the rotating pointer and the one-hot form of the lock owner.
  always_comb begin
    thermo_s     = '0;
    owner_1hot_s = '0;
    for (int k = 0; k < N; k++) begin
      thermo_s[k]     = (ID_W'(k) >= ptr_r);
      owner_1hot_s[k] = (owner_r == ID_W'(k));
    end
  end

  assign masked_req_s = req_valid_i & thermo_s;

  hpdcache_prio_1hot_encoder #(.N(N)) u_enc_masked (
    .req (masked_req_s),
    .gnt (masked_gnt_s)
  );

  hpdcache_prio_1hot_encoder #(.N(N)) u_enc_raw (
    .req (req_valid_i),
    .gnt (raw_gnt_s)
  );

  // Rotating pick: requesters at/after the pointer first, otherwise wrap to the lowest index.
  always_comb begin
    if (|masked_gnt_s) begin
      pick_s = masked_gnt_s;
    end else begin
      pick_s = raw_gnt_s;
    end
  end

  // Grant source depends on whether a burst currently holds the channel.
  always_comb begin
    case (state_r)
      ARB_IDLE:   gnt_s = pick_s;
      ARB_LOCKED: gnt_s = owner_1hot_s & req_valid_i;
      default:    gnt_s = '0;
    endcase
  end

  assign can_load_s  = ~out_valid_r | out_ready_i;
  assign ready_s     = gnt_s & {N{can_load_s & rst_ni}};
  assign req_ready_o = ready_s;
  assign xfer_s      = |ready_s;
  assign last_in_s   = |(gnt_s & req_last_i);

  // One-hot grant to index, and AND-OR payload mux.
  always_comb begin
    gnt_idx_s  = '0;
    data_mux_s = '0;
    for (int k = 0; k < N; k++) begin
      gnt_idx_s  = gnt_idx_s | (gnt_s[k] ? ID_W'(k) : ID_W'(0));
      data_mux_s = data_mux_s | (req_data_i[k*DATA_W +: DATA_W] & {DATA_W{gnt_s[k]}});
    end
  end

  // Next state: lock on a non-final first beat, release on last or on reaching MAX_BEATS.
  always_comb begin
    state_n_s    = state_r;
    owner_n_s    = owner_r;
    ptr_n_s      = ptr_r;
    beat_cnt_n_s = beat_cnt_r;
    burst_end_s  = 1'b0;
    trunc_s      = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (xfer_s) begin
          if (last_in_s || SINGLE_BEAT) begin
            burst_end_s = 1'b1;
            trunc_s     = ~last_in_s;
            ptr_n_s     = next_ptr(gnt_idx_s);
          end else begin
            owner_n_s    = gnt_idx_s;
            beat_cnt_n_s = CNT_W'(1);
            state_n_s    = ARB_LOCKED;
          end
        end else begin
          state_n_s = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (xfer_s) begin
          if (last_in_s || (beat_cnt_r == CNT_TRUNC)) begin
            burst_end_s  = 1'b1;
            trunc_s      = ~last_in_s;
            beat_cnt_n_s = '0;
            ptr_n_s      = next_ptr(owner_r);
            state_n_s    = ARB_IDLE;
          end else begin
            beat_cnt_n_s = beat_cnt_r + CNT_W'(1);
          end
        end else begin
          state_n_s = ARB_LOCKED;
        end
      end
      default: begin
        state_n_s    = ARB_IDLE;
        beat_cnt_n_s = '0;
      end
    endcase
  end

  // Arbitration state register; reset drops any lock in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ARB_IDLE;
      owner_r    <= '0;
      ptr_r      <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_n_s;
      owner_r    <= owner_n_s;
      ptr_r      <= ptr_n_s;
      beat_cnt_r <= beat_cnt_n_s;
    end
  end

  // Output beat register: loads when empty or draining, otherwise holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_id_r    <= '0;
      err_burst_r <= 1'b0;
    end else begin
      err_burst_r <= trunc_s;
      if (can_load_s) begin
        out_valid_r <= xfer_s;
        if (xfer_s) begin
          out_data_r <= data_mux_s;
          out_last_r <= burst_end_s;
          out_id_r   <= gnt_idx_s;
        end
      end
    end
  end

  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign out_last_o  = out_last_r;
  assign out_id_o    = out_id_r;
  assign err_burst_o = err_burst_r;

  hpdcache_burst_arb_chk #(.N(N), .DATA_W(DATA_W), .ID_W(ID_W)) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_ready  (ready_s),
    .owner_1hot (owner_1hot_s),
    .locked     (state_r == ARB_LOCKED),
    .out_valid  (out_valid_r),
    .out_ready  (out_ready_i),
    .out_data   (out_data_r),
    .out_last   (out_last_r),
    .out_id     (out_id_r)
  );

endmodule
